// File: rtl/accum_mc_if.sv
// accum_mc_if: request/response bundle for the multi-channel accumulator.
// It carries the configuration inputs, the tagged request stream and the
// shared result stream. The accumulator connects to the slave modport and
// the producer/consumer side connects to the master modport.
interface accum_mc_if #(
   parameter int p_width = 16,
   parameter int p_nchan = 4,
   parameter int p_max_n = 16
);
   localparam int cw = (p_nchan > 1) ? $clog2(p_nchan) : 1;
   localparam int nw = $clog2(p_max_n + 1);

   logic [nw-1:0]      cfg_n;
   logic [1:0]         cfg_mode;
   logic               req_val;
   logic               req_rdy;
   logic [cw-1:0]      req_chan;
   logic [p_width-1:0] req_msg;
   logic               resp_val;
   logic               resp_rdy;
   logic [cw-1:0]      resp_chan;
   logic [p_width-1:0] resp_msg;

   modport master (
      output cfg_n, cfg_mode, req_val, req_chan, req_msg, resp_rdy,
      input  req_rdy, resp_val, resp_chan, resp_msg
   );

   modport slave (
      input  cfg_n, cfg_mode, req_val, req_chan, req_msg, resp_rdy,
      output req_rdy, resp_val, resp_chan, resp_msg
   );
endinterface

// File: rtl/accum_mc.sv
// accum_mc: multi-channel, mode-configurable accumulator.
// Each of p_nchan channels folds cfg_n tagged messages into one result
// (sum / unsigned max / unsigned min / xor). Completed results leave through
// a single round-robin arbitrated response port. A response and a new
// request to the same channel may complete in the same cycle, so a channel
// holding a result can restart without a bubble.
// Optional build macro: ACCUM_MC_SATURATE_EN makes the sum mode saturate at
// all-ones instead of wrapping.
module accum_mc #(
   parameter int p_width = 16,
   parameter int p_nchan = 4,
   parameter int p_max_n = 16
) (
   input logic        clk,
   input logic        reset,
   accum_mc_if.slave  bus
);
   localparam int cw = (p_nchan > 1) ? $clog2(p_nchan) : 1;
   localparam int nw = $clog2(p_max_n + 1);

   logic [nw-1:0]      cnt_q  [p_nchan];
   logic [p_width-1:0] acc_q  [p_nchan];
   logic [p_nchan-1:0] done_q;
   logic [cw-1:0]      last_q;
   logic               hold_q;
   logic [cw-1:0]      hold_chan_q;
   logic [nw-1:0]      n_sh_q;
   logic [1:0]         mode_sh_q;

   logic [cw-1:0]      grant;
   logic               resp_val_i;
   logic               resp_go;
   logic               req_rdy_i;
   logic               req_go;
   logic               chan_ok;
   logic               all_idle;

   // 0 means one message per set; anything above p_max_n is clamped
   function automatic logic [nw-1:0] clamp_n(input logic [nw-1:0] n);
      if (n == '0) return nw'(1);
      if (int'(n) > p_max_n) return nw'(p_max_n);
      return n;
   endfunction

   function automatic logic [p_width-1:0] add_op(input logic [p_width-1:0] a,
                                                 input logic [p_width-1:0] b);
`ifdef ACCUM_MC_SATURATE_EN
      logic [p_width:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[p_width] ? '1 : s[p_width-1:0];
`else
      return a + b;
`endif
   endfunction

   function automatic logic [p_width-1:0] combine(input logic [1:0]         mode,
                                                  input logic [p_width-1:0] a,
                                                  input logic [p_width-1:0] b);
      case (mode)
         2'd0:    return add_op(a, b);
         2'd1:    return (a >= b) ? a : b;
         2'd2:    return (a <= b) ? a : b;
         default: return a ^ b;
      endcase
   endfunction

   // first done channel strictly after the last grant, wrapping around
   function automatic logic [cw-1:0] rr_pick(input logic [p_nchan-1:0] d,
                                             input logic [cw-1:0]      last);
      logic [cw-1:0] pick;
      logic [cw-1:0] idx;
      logic          found;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= p_nchan; i++) begin
         idx = cw'((int'(last) + i) % p_nchan);
         if (!found && d[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // response selection and handshake qualification
   always_comb begin
      grant      = hold_q ? hold_chan_q : rr_pick(done_q, last_q);
      resp_val_i = ~reset & (|done_q);
      resp_go    = resp_val_i & bus.resp_rdy;
      chan_ok    = int'(bus.req_chan) < p_nchan;
      req_rdy_i  = ~reset & chan_ok &
                   (~done_q[bus.req_chan] | (resp_go & (grant == bus.req_chan)));
      req_go     = bus.req_val & req_rdy_i;
      all_idle   = 1'b1;
      for (int c = 0; c < p_nchan; c++) begin
         if ((cnt_q[c] != '0) || done_q[c]) all_idle = 1'b0;
      end
   end

   assign bus.req_rdy   = req_rdy_i;
   assign bus.resp_val  = resp_val_i;
   assign bus.resp_chan = resp_val_i ? grant : '0;
   assign bus.resp_msg  = resp_val_i ? acc_q[grant] : '0;

   // per-channel count / accumulate / done bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < p_nchan; c++) begin
            cnt_q[c] <= '0;
            acc_q[c] <= '0;
         end
         done_q <= '0;
      end else begin
         for (int c = 0; c < p_nchan; c++) begin
            if (req_go && (int'(bus.req_chan) == c)) begin
               // cnt is 0 both for a fresh set and for a bypass restart
               acc_q[c] <= (cnt_q[c] == '0) ? bus.req_msg
                                            : combine(mode_sh_q, acc_q[c], bus.req_msg);
               if (cnt_q[c] == n_sh_q - 1'b1) begin
                  done_q[c] <= 1'b1;
                  cnt_q[c]  <= '0;
               end else begin
                  done_q[c] <= 1'b0;
                  cnt_q[c]  <= cnt_q[c] + 1'b1;
               end
            end else if (resp_go && (int'(grant) == c)) begin
               done_q[c] <= 1'b0;
            end
         end
      end
   end

   // round-robin pointer and grant hold while the consumer stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q      <= cw'(p_nchan - 1);
         hold_q      <= 1'b0;
         hold_chan_q <= '0;
      end else begin
         if (resp_go) last_q <= grant;
         hold_q      <= resp_val_i & ~bus.resp_rdy;
         hold_chan_q <= grant;
      end
   end

   // configuration shadows follow the inputs only while fully idle
   always_ff @(posedge clk) begin
      if (reset) begin
         n_sh_q    <= nw'(1);
         mode_sh_q <= 2'd0;
      end else if (all_idle && !req_go) begin
         n_sh_q    <= clamp_n(bus.cfg_n);
         mode_sh_q <= bus.cfg_mode;
      end
   end
endmodule

// File: tb/tb_accum_mc.sv
// tb_accum_mc: directed bench for accum_mc with hand-computed results.
module tb_accum_mc;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   accum_mc_if #(.p_width(16), .p_nchan(4), .p_max_n(16)) bus ();

   accum_mc #(.p_width(16), .p_nchan(4), .p_max_n(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // move to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one request for one cycle; report req_rdy seen before the edge
   task automatic send(input int ch, input logic [15:0] m, output logic rdy);
      logic [31:0] chv;
      chv          = ch;
      bus.req_val  = 1'b1;
      bus.req_chan = chv[1:0];
      bus.req_msg  = m;
      @(negedge clk);
      rdy = bus.req_rdy;
      step();
      bus.req_val = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.req_val  = 1'b1;
      bus.req_chan = 2'd1;
      bus.req_msg  = 16'h1234;
      bus.resp_rdy = 1'b1;
      bus.cfg_n    = 5'd1;
      bus.cfg_mode = 2'd0;
      step();
      step();
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL rst_resp_val: got %b want 0", bus.resp_val); end
      checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy: got %b want 0", bus.req_rdy); end
      checks++; if (bus.resp_chan !== 2'd0) begin errors++; $display("FAIL rst_resp_chan: got %0d want 0", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'h0) begin errors++; $display("FAIL rst_resp_msg: got %h want 0000", bus.resp_msg); end
      step();
      reset       = 1'b0;
      bus.req_val = 1'b0;
      step();
   endtask

   task automatic test_basic_sum();
      logic r;
      bus.cfg_n    = 5'd4;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b1;
      step();
      for (int i = 1; i <= 4; i++) begin
         send(2, 16'(i), r);
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL sum_rdy%0d: got %b want 1", i, r); end
         if (i < 4) begin
            #1;
            checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL sum_early%0d: got %b want 0", i, bus.resp_val); end
         end
      end
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b1) begin errors++; $display("FAIL sum_val: got %b want 1", bus.resp_val); end
      checks++; if (bus.resp_chan !== 2'd2) begin errors++; $display("FAIL sum_chan: got %0d want 2", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd10) begin errors++; $display("FAIL sum_msg: got %0d want 10", bus.resp_msg); end
      step();
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL sum_drain: got %b want 0", bus.resp_val); end
      step();
   endtask

   task automatic test_interleave();
      logic r;
      bus.cfg_n    = 5'd2;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b1;
      step();
      send(0, 16'd5, r);
      send(1, 16'd7, r);
      send(0, 16'd6, r);
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b1) begin errors++; $display("FAIL il_val0: got %b want 1", bus.resp_val); end
      checks++; if (bus.resp_chan !== 2'd0) begin errors++; $display("FAIL il_chan0: got %0d want 0", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd11) begin errors++; $display("FAIL il_msg0: got %0d want 11", bus.resp_msg); end
      step();
      send(1, 16'd8, r);
      @(negedge clk);
      checks++; if (bus.resp_chan !== 2'd1) begin errors++; $display("FAIL il_chan1: got %0d want 1", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd15) begin errors++; $display("FAIL il_msg1: got %0d want 15", bus.resp_msg); end
      step();
      // both channels complete while the consumer stalls
      bus.resp_rdy = 1'b0;
      send(0, 16'd2, r);
      send(1, 16'd1, r);
      send(0, 16'd4, r);
      send(1, 16'd3, r);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL il_nostall: got %b want 1", r); end
      @(negedge clk);
      checks++; if (bus.resp_chan !== 2'd0) begin errors++; $display("FAIL il_hold_chan: got %0d want 0", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd6) begin errors++; $display("FAIL il_hold_msg: got %0d want 6", bus.resp_msg); end
      step();
      @(negedge clk);
      checks++; if (bus.resp_chan !== 2'd0) begin errors++; $display("FAIL il_stable_chan: got %0d want 0", bus.resp_chan); end
      step();
      bus.resp_rdy = 1'b1;
      @(negedge clk);
      checks++; if (bus.resp_msg !== 16'd6) begin errors++; $display("FAIL il_rr0_msg: got %0d want 6", bus.resp_msg); end
      step();
      @(negedge clk);
      checks++; if (bus.resp_chan !== 2'd1) begin errors++; $display("FAIL il_rr1_chan: got %0d want 1", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd4) begin errors++; $display("FAIL il_rr1_msg: got %0d want 4", bus.resp_msg); end
      step();
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL il_drain: got %b want 0", bus.resp_val); end
      step();
   endtask

   task automatic test_bypass();
      logic r;
      bus.cfg_n    = 5'd1;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b0;
      step();
      send(3, 16'h0021, r);
      @(negedge clk);
      checks++; if (bus.resp_chan !== 2'd3) begin errors++; $display("FAIL bp_chan: got %0d want 3", bus.resp_chan); end
      step();
      bus.req_val  = 1'b1;
      bus.req_chan = 2'd3;
      bus.req_msg  = 16'd9;
      @(negedge clk);
      checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL bp_blocked: got %b want 0", bus.req_rdy); end
      step();
      bus.resp_rdy = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy: got %b want 1", bus.req_rdy); end
      checks++; if (bus.resp_msg !== 16'h0021) begin errors++; $display("FAIL bp_old_msg: got %h want 0021", bus.resp_msg); end
      step();
      bus.req_val = 1'b0;
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b1) begin errors++; $display("FAIL bp_new_val: got %b want 1", bus.resp_val); end
      checks++; if (bus.resp_chan !== 2'd3) begin errors++; $display("FAIL bp_new_chan: got %0d want 3", bus.resp_chan); end
      checks++; if (bus.resp_msg !== 16'd9) begin errors++; $display("FAIL bp_new_msg: got %0d want 9", bus.resp_msg); end
      step();
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.resp_val); end
      step();
   endtask

   task automatic test_modes();
      logic        r;
      logic [15:0] want [3];
      want[0] = 16'hFFFF;
      want[1] = 16'h0003;
      want[2] = 16'hFFEC;
      bus.cfg_n    = 5'd3;
      bus.resp_rdy = 1'b1;
      for (int m = 1; m <= 3; m++) begin
         bus.cfg_mode = 2'(m);
         step();
         send(1, 16'h0010, r);
         send(1, 16'hFFFF, r);
         send(1, 16'h0003, r);
         @(negedge clk);
         checks++; if (bus.resp_chan !== 2'd1) begin errors++; $display("FAIL mode%0d_chan: got %0d want 1", m, bus.resp_chan); end
         checks++; if (bus.resp_msg !== want[m-1]) begin errors++; $display("FAIL mode%0d_msg: got %h want %h", m, bus.resp_msg, want[m-1]); end
         step();
      end
   endtask

   task automatic test_overflow();
      logic        r;
      logic [15:0] want;
`ifdef ACCUM_MC_SATURATE_EN
      want = 16'hFFFF;
`else
      want = 16'h0001;
`endif
      bus.cfg_n    = 5'd2;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b1;
      step();
      send(0, 16'hFFFF, r);
      send(0, 16'h0002, r);
      @(negedge clk);
      checks++; if (bus.resp_msg !== want) begin errors++; $display("FAIL ovf_msg: got %h want %h", bus.resp_msg, want); end
      step();
   endtask

   task automatic test_reset_mid();
      logic r;
      bus.cfg_n    = 5'd4;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b1;
      step();
      send(2, 16'd1, r);
      send(2, 16'd2, r);
      reset        = 1'b1;
      bus.req_val  = 1'b1;
      bus.req_chan = 2'd2;
      @(negedge clk);
      checks++; if (bus.req_rdy !== 1'b0) begin errors++; $display("FAIL rmid_rdy: got %b want 0", bus.req_rdy); end
      step();
      reset       = 1'b0;
      bus.req_val = 1'b0;
      step();
      send(2, 16'd10, r);
      send(2, 16'd20, r);
      send(2, 16'd30, r);
      #1;
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL rmid_stale: got %b want 0", bus.resp_val); end
      send(2, 16'd40, r);
      @(negedge clk);
      checks++; if (bus.resp_msg !== 16'd100) begin errors++; $display("FAIL rmid_msg: got %0d want 100", bus.resp_msg); end
      step();
   endtask

   task automatic test_cfg_change();
      logic r;
      bus.cfg_n    = 5'd4;
      bus.cfg_mode = 2'd0;
      bus.resp_rdy = 1'b1;
      step();
      send(0, 16'd1, r);
      send(0, 16'd1, r);
      bus.cfg_n = 5'd2;
      send(0, 16'd1, r);
      #1;
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL cfg_early: got %b want 0", bus.resp_val); end
      send(0, 16'd1, r);
      @(negedge clk);
      checks++; if (bus.resp_msg !== 16'd4) begin errors++; $display("FAIL cfg_old_msg: got %0d want 4", bus.resp_msg); end
      step();
      step();
      send(0, 16'd3, r);
      #1;
      checks++; if (bus.resp_val !== 1'b0) begin errors++; $display("FAIL cfg_new_early: got %b want 0", bus.resp_val); end
      send(0, 16'd4, r);
      @(negedge clk);
      checks++; if (bus.resp_val !== 1'b1) begin errors++; $display("FAIL cfg_new_val: got %b want 1", bus.resp_val); end
      checks++; if (bus.resp_msg !== 16'd7) begin errors++; $display("FAIL cfg_new_msg: got %0d want 7", bus.resp_msg); end
      step();
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      reset        = 1'b1;
      bus.req_val  = 1'b0;
      bus.req_chan = 2'd0;
      bus.req_msg  = 16'h0;
      bus.resp_rdy = 1'b0;
      bus.cfg_n    = 5'd1;
      bus.cfg_mode = 2'd0;
      test_reset();
      test_basic_sum();
      test_interleave();
      test_bypass();
      test_modes();
      test_overflow();
      test_reset_mid();
      test_cfg_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
